screen_scan: RTL and testbench
==============================

SCREEN_SCAN -- requirements
Module: screen_scan

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 512: visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16; H_SYNC, default 64; H_BP, default 48: horizontal porch and sync lengths in clocks. H_TOTAL = 640.
REQ-003 SHALL have parameter V_ACTIVE, default 256; V_FP, default 4; V_SYNC, default 4; V_BP, default 16: vertical timing in lines. V_TOTAL = 280.
REQ-004 SHALL have port clock  in  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-low reset (0 = reset).
REQ-006 SHALL have port enable  in  1  scan request; sampled only at frame boundaries.
REQ-007 SHALL have port rd_en  out  1  read strobe to screen memory.
REQ-008 SHALL have port rd_addr  out  13  screen word address (0..8191).
REQ-009 SHALL have port rd_data  in  16  screen word, valid exactly 1 clock after rd_en.
REQ-010 SHALL have port pixel  out  1  current pixel, 1 = black.
REQ-011 SHALL have port de  out  1  pixel is in the visible region.
REQ-012 SHALL have ports hsync and vsync  out  1 each  active-low syncs.
REQ-013 SHALL have port frame_start  out  1  one-clock pulse on the first pixel of each frame.

Function
REQ-014 SHALL keep hcount (0..H_TOTAL-1) and vcount (0..V_TOTAL-1) counters, one pixel per clock.
- hcount wraps to 0 and increments vcount.
- vcount wraps to 0 after V_TOTAL-1.
REQ-015 SHALL implement states IDLE and SCAN.
- reset -> IDLE.
- IDLE with enable=1 -> SCAN, starting at (0,0) on the next clock.
- SCAN at (H_TOTAL-1, V_TOTAL-1): enable=1 stays SCAN; enable=0 -> IDLE.
REQ-016 In IDLE, SHALL hold both counters at 0 and drive rd_en=0, de=0, pixel=0, hsync=1, vsync=1, frame_start=0.
REQ-017 In SCAN with hcount<H_ACTIVE, vcount<V_ACTIVE and hcount[3:0]=0, SHALL assert rd_en for one clock with rd_addr = vcount*32 + hcount[8:4]; otherwise rd_en=0 and rd_addr holds its last value.
REQ-018 SHALL capture rd_data into a 16-bit shift register one clock after rd_en, and SHALL output bit i of the word at the pixel with hcount[3:0]=i (bit 0 is leftmost).
REQ-019 For counter position (h,v), SHALL present pixel, de, hsync and vsync exactly 2 clocks after the counters reach (h,v); all four outputs SHALL be registered.
- hsync=0 for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
- vsync=0 for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
REQ-020 SHALL force pixel=0 whenever de=0.
REQ-021 SHALL assert frame_start in the same clock that the pixel for (0,0) is output.
REQ-022 Deasserting enable mid-frame SHALL NOT truncate the frame; the scan SHALL stop only at the frame end.
REQ-023 The two trailing pipeline clocks after leaving SCAN SHALL drain normally; no rd_en SHALL be issued in IDLE.

Reset
REQ-024 With reset=0 at a clock edge, SHALL go to IDLE, clear counters, the shift register and the pipeline, and drive the REQ-016 values from the next clock.
REQ-025 Reset mid-frame SHALL abort the frame immediately; frame_start SHALL NOT fire until the next SCAN entry.

Configuration
REQ-026 With SCREEN_SCAN_FRAMECNT_EN defined, SHALL add output frame_count [15:0].
- Reset value 0.
- Increments in the frame_start clock; wraps 65535 -> 0.
REQ-027 Without SCREEN_SCAN_FRAMECNT_EN, the frame_count port and its logic SHALL NOT exist; all other behaviour is identical.

Structure
REQ-028 Package screen_scan_pkg SHALL hold the default timing constants, WORDS_PER_ROW=32, SCREEN_WORDS=8192, and the IDLE/SCAN state encoding.
REQ-029 SHALL instantiate one sub-module scan_timing, which owns hcount/vcount, the sync windows and the visible-region flag.

Verification
REQ-030 Reset low for 3 clocks, enable=1 -> IDLE values held; frame_start first seen 3 clocks after reset release (1 clock to enter SCAN plus 2 pipeline clocks).
REQ-031 Memory model with word[a]=a -> rd_addr sequence 0,1,...,8191 per frame; rd_en pulses spaced 16 clocks apart within a line; 32 pulses per line; 8192 pulses per frame.
REQ-032 word[0]=16'h0001, all other words 0 -> exactly one black pixel per frame, coinciding with frame_start.
REQ-033 Sync check -> hsync low for 64 clocks starting 528 clocks after a line's first de; vsync low for 4 lines; period 640x280 = 179200 clocks.
REQ-034 Drop enable at line 100 -> frame completes; vsync pulse occurs; then IDLE. Drop reset at line 100 -> outputs idle within 1 clock; no further rd_en.
REQ-035 With SCREEN_SCAN_FRAMECNT_EN and preload via 65536 frames (or a forced count) -> frame_count wraps 65535 -> 0.

Source files
------------

// File: rtl/screen_scan_pkg.sv
// screen_scan_pkg -- shared constants and types for the screen scanner.
//
// Holds the default video timing (512x256 visible, 640x280 total), the
// screen memory geometry, counter/address widths and the scanner state
// encoding. Imported by screen_scan and scan_timing.

package screen_scan_pkg;

    // Default horizontal timing in clocks (H_TOTAL = 640).
    localparam int H_ACTIVE_DEF = 512;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 64;
    localparam int H_BP_DEF     = 48;

    // Default vertical timing in lines (V_TOTAL = 280).
    localparam int V_ACTIVE_DEF = 256;
    localparam int V_FP_DEF     = 4;
    localparam int V_SYNC_DEF   = 4;
    localparam int V_BP_DEF     = 16;

    // Screen memory geometry: 32 words of 16 pixels per row, 8192 words.
    localparam int WORDS_PER_ROW = 32;
    localparam int SCREEN_WORDS  = 8192;

    // Counter width covers totals up to 4095; address spans SCREEN_WORDS.
    localparam int CNT_W  = 12;
    localparam int ADDR_W = 13;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

endpackage

// File: rtl/scan_timing.sv
// scan_timing -- raster position counters and timing windows.
//
// Owns hcount/vcount. While run is high the counters advance one pixel per
// clock and wrap at the frame end; while run is low they are held at 0.
// All window flags are gated by run so nothing looks active when idle.
//
// Ports:
//   clock     in   rising-edge clock
//   reset     in   synchronous active-low reset
//   run       in   scanner is in SCAN
//   visible   out  current position is in the visible region
//   hsync     out  active-low horizontal sync window (unregistered)
//   vsync     out  active-low vertical sync window (unregistered)
//   first     out  current position is (0,0)
//   last      out  current position is (H_TOTAL-1, V_TOTAL-1)
//   word_addr out  screen word address for the current position
//   phase     out  pixel index within the current 16-pixel word

module scan_timing
    import screen_scan_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
)
(
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    output logic              visible,
    output logic              hsync,
    output logic              vsync,
    output logic              first,
    output logic              last,
    output logic [ADDR_W-1:0] word_addr,
    output logic [3:0]        phase
);

    localparam logic [CNT_W-1:0] H_VIS  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_SS   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SE   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] V_VIS  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_SS   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SE   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;

    always_ff @(posedge clock) begin
        if (!reset || !run) begin
            hcount <= '0;
            vcount <= '0;
        end else if (hcount == H_LAST) begin
            hcount <= '0;
            vcount <= (vcount == V_LAST) ? '0 : vcount + 1'b1;
        end else begin
            hcount <= hcount + 1'b1;
        end
    end

    assign visible = run && (hcount < H_VIS) && (vcount < V_VIS);
    assign hsync   = !(run && (hcount >= H_SS) && (hcount < H_SE));
    assign vsync   = !(run && (vcount >= V_SS) && (vcount < V_SE));
    assign first   = run && (hcount == '0) && (vcount == '0);
    assign last    = run && (hcount == H_LAST) && (vcount == V_LAST);

    // vcount*WORDS_PER_ROW + hcount[8:4]; with 32 words per row the sum is
    // a plain concatenation, truncated to the 13-bit screen address.
    assign word_addr = {vcount[7:0], hcount[8:4]};
    assign phase     = hcount[3:0];

endmodule

// File: rtl/screen_scan.sv
// screen_scan -- monochrome raster scanner reading 16-pixel words from
// screen memory and producing pixel/de/hsync/vsync.
//
// Pipeline: cycle C counters at (h,v), rd_en/rd_addr issued combinationally;
// cycle C+1 rd_data valid, stage-1 flags registered; cycle C+2 registered
// pixel/de/hsync/vsync/frame_start for (h,v).
//
// Ports:
//   clock        in   sole clock, rising edge
//   reset        in   synchronous active-low reset
//   enable       in   scan request, acted on only at frame boundaries
//   rd_en        out  read strobe to screen memory
//   rd_addr      out  screen word address (holds last value between reads)
//   rd_data      in   screen word, valid one clock after rd_en
//   pixel        out  current pixel, 1 = black (0 outside visible region)
//   de           out  pixel is in the visible region
//   hsync/vsync  out  active-low syncs
//   frame_start  out  one-clock pulse with the (0,0) pixel
//   dbg_state    out  scanner FSM state
//   frame_count  out  frames started, 16-bit wrapping
//                     (only with SCREEN_SCAN_FRAMECNT_EN defined)

module screen_scan
    import screen_scan_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
)
(
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [15:0]       rd_data,
    output logic              pixel,
    output logic              de,
    output logic              hsync,
    output logic              vsync,
    output logic              frame_start,
    output state_e            dbg_state
`ifdef SCREEN_SCAN_FRAMECNT_EN
    ,
    output logic [15:0]       frame_count
`endif
);

    state_e state;
    state_e state_nxt;

    logic              run;
    logic              visible;
    logic              hs_raw;
    logic              vs_raw;
    logic              first;
    logic              last;
    logic [ADDR_W-1:0] word_addr;
    logic [3:0]        phase;

    logic [ADDR_W-1:0] addr_q;
    logic              vis_s1;
    logic              hs_s1;
    logic              vs_s1;
    logic              load_s1;
    logic              first_s1;
    logic [15:0]       shreg;
    logic              pixel_bit;

    assign run       = (state == SCAN);
    assign dbg_state = state;

    scan_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clock     (clock),
        .reset     (reset),
        .run       (run),
        .visible   (visible),
        .hsync     (hs_raw),
        .vsync     (vs_raw),
        .first     (first),
        .last      (last),
        .word_addr (word_addr),
        .phase     (phase)
    );

    // Scanner FSM.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // enable is only looked at in IDLE and on the last pixel of a frame,
    // so dropping it mid-frame lets the frame finish.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = SCAN;
            SCAN:    if (last && !enable) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One read per 16-pixel word, on the word's first visible pixel.
    assign rd_en   = visible && (phase == 4'd0);
    assign rd_addr = rd_en ? word_addr : addr_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            addr_q <= '0;
        end else if (rd_en) begin
            addr_q <= word_addr;
        end
    end

    // Stage 1: registered position flags, aligned with rd_data.
    always_ff @(posedge clock) begin
        if (!reset) begin
            vis_s1   <= 1'b0;
            hs_s1    <= 1'b1;
            vs_s1    <= 1'b1;
            load_s1  <= 1'b0;
            first_s1 <= 1'b0;
        end else begin
            vis_s1   <= visible;
            hs_s1    <= hs_raw;
            vs_s1    <= vs_raw;
            load_s1  <= rd_en;
            first_s1 <= first;
        end
    end

    // Bit 0 of the fresh word is used directly on the load clock; the
    // register keeps the remaining bits shifted right so bit i reaches
    // position 0 on the i-th pixel of the word.
    always_ff @(posedge clock) begin
        if (!reset) begin
            shreg <= '0;
        end else if (load_s1) begin
            shreg <= {1'b0, rd_data[15:1]};
        end else begin
            shreg <= {1'b0, shreg[15:1]};
        end
    end

    assign pixel_bit = load_s1 ? rd_data[0] : shreg[0];

    // Stage 2: registered outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            de          <= 1'b0;
            pixel       <= 1'b0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            de          <= vis_s1;
            pixel       <= vis_s1 & pixel_bit;
            hsync       <= hs_s1;
            vsync       <= vs_s1;
            frame_start <= first_s1;
        end
    end

`ifdef SCREEN_SCAN_FRAMECNT_EN
    // Advances on the same edge that raises frame_start.
    always_ff @(posedge clock) begin
        if (!reset) begin
            frame_count <= '0;
        end else if (first_s1) begin
            frame_count <= frame_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_screen_scan.sv
// tb_screen_scan -- self-checking bench for screen_scan with a reduced
// raster (80x14 total) so several frames fit in a short run. A reference
// model tracks the frame position as a single index and derives every
// expected output from it arithmetically, two clocks late. Optional
// SCREEN_SCAN_FRAMECNT_EN adds the frame_count comparison.

module tb_screen_scan;
  import screen_scan_pkg::*;

  localparam int HA = 64;
  localparam int HF = 4;
  localparam int HS = 8;
  localparam int HB = 4;
  localparam int HT = HA + HF + HS + HB;
  localparam int VA = 8;
  localparam int VF = 2;
  localparam int VS = 2;
  localparam int VB = 2;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int RD_PER_FRAME = VA * (HA / 16);

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        rd_en;
  logic [12:0] rd_addr;
  logic [15:0] rd_data;
  logic        pixel;
  logic        de;
  logic        hsync;
  logic        vsync;
  logic        frame_start;
  state_e      dbg_state;
`ifdef SCREEN_SCAN_FRAMECNT_EN
  logic [15:0] frame_count;
`endif

  logic [15:0] mem [0:8191];

  // model state: position index in frame, -1 = not scanning
  int cur, d1, outp, addr_last, fc;
  int checks, failures;
  int cyc, first_fs, rd_cnt, blk_cnt, fs_cnt, vs_cnt;

  screen_scan #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .pixel       (pixel),
    .de          (de),
    .hsync       (hsync),
    .vsync       (vsync),
    .frame_start (frame_start),
    .dbg_state   (dbg_state)
`ifdef SCREEN_SCAN_FRAMECNT_EN
    ,
    .frame_count (frame_count)
`endif
  );

  // clock / reset block
  always #5 clock = ~clock;

  // screen memory: data one clock after rd_en, garbage otherwise
  always @(posedge clock) rd_data <= rd_en ? mem[rd_addr] : 16'($urandom);

  function automatic bit vis(input int p);
    if (p < 0) return 1'b0;
    return ((p % HT) < HA) && ((p / HT) < VA);
  endfunction

  function automatic int addr_of(input int p);
    return ((p / HT) * 32 + ((p % HT) / 16) % 32) % 8192;
  endfunction

  function automatic bit rd_exp(input int p);
    return vis(p) && ((p % HT) % 16 == 0);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      if (failures <= 20)
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock: advance the model, then compare every output
  task automatic step();
    int h, v;
    bit ex_hs, ex_vs, ex_px, ex_rd;
    int ex_addr;
    @(posedge clock);
    cyc++;
    if (!reset) begin
      cur = -1; d1 = -1; outp = -1; addr_last = 0; fc = 0;
    end else begin
      if (rd_exp(cur)) addr_last = addr_of(cur);
      outp = d1;
      d1 = cur;
      if (cur < 0 || cur == FRAME - 1) cur = enable ? 0 : -1;
      else cur = cur + 1;
      if (outp == 0) fc = (fc + 1) % 65536;
    end
    #1;
    ex_hs = 1'b1; ex_vs = 1'b1; ex_px = 1'b0;
    if (outp >= 0) begin
      h = outp % HT;
      v = outp / HT;
      ex_hs = !(h >= HA + HF && h < HA + HF + HS);
      ex_vs = !(v >= VA + VF && v < VA + VF + VS);
      if (vis(outp)) ex_px = mem[addr_of(outp)][h % 16];
    end
    ex_rd = rd_exp(cur);
    ex_addr = ex_rd ? addr_of(cur) : addr_last;
    check("state", dbg_state == SCAN, cur >= 0);
    check("rd_en", rd_en, ex_rd);
    check("rd_addr", rd_addr, ex_addr);
    check("de", de, vis(outp));
    check("pixel", pixel, ex_px);
    check("hsync", hsync, ex_hs);
    check("vsync", vsync, ex_vs);
    check("frame_start", frame_start, outp == 0);
`ifdef SCREEN_SCAN_FRAMECNT_EN
    check("frame_count", frame_count, fc);
`endif
    if (rd_en === 1'b1) rd_cnt++;
    if (pixel === 1'b1) blk_cnt++;
    if (frame_start === 1'b1) begin
      fs_cnt++;
      if (first_fs < 0) first_fs = cyc;
    end
    if (vsync === 1'b0) vs_cnt++;
  endtask

  initial begin
    checks = 0; failures = 0;
    cur = -1; d1 = -1; outp = -1; addr_last = 0; fc = 0;
    cyc = 0; first_fs = -1; rd_cnt = 0; blk_cnt = 0; fs_cnt = 0; vs_cnt = 0;
    for (int i = 0; i < 8192; i++) mem[i] = 16'($urandom);

    // reset held low with enable high: idle values
    reset = 1'b0;
    enable = 1'b1;
    repeat (3) step();

    // release: two back-to-back frames of random screen data
    reset = 1'b1;
    cyc = 0; first_fs = -1; rd_cnt = 0;
    repeat (2 * FRAME) step();
    check("first_frame_start_delay", first_fs, 3);
    check("rd_pulses_two_frames", rd_cnt, 2 * RD_PER_FRAME);

    // drop enable at line 5: frame completes with its vsync, then idle
    repeat (5 * HT) step();
    enable = 1'b0;
    rd_cnt = 0; vs_cnt = 0;
    repeat (FRAME) step();
    check("rd_pulses_after_drop", rd_cnt, (VA - 5) * (HA / 16));
    check("vsync_low_after_drop", vs_cnt, VS * HT);
    check("idle_after_drop", dbg_state == SCAN, 0);

    // single black pixel at word 0 bit 0, coinciding with frame_start
    for (int i = 0; i < 8192; i++) mem[i] = 16'h0000;
    mem[0] = 16'h0001;
    enable = 1'b1;
    blk_cnt = 0; fs_cnt = 0;
    repeat (FRAME + 2) step();
    check("black_pixels_per_frame", blk_cnt, 1);
    check("frame_starts_per_frame", fs_cnt, 1);
    enable = 1'b0;
    repeat (FRAME) step();

    // random enable, random screen contents (changed only while idle)
    for (int i = 0; i < 8192; i++) mem[i] = 16'($urandom);
    repeat (3 * FRAME) begin
      enable = ($urandom_range(0, 3) != 0);
      step();
    end

    // reset mid-frame: idle next clock, no further reads or frame_start
    enable = 1'b1;
    repeat (FRAME + 5 * HT) step();
    enable = 1'b0;
    reset = 1'b0;
    step();
    check("de_after_reset", de, 0);
    check("hsync_after_reset", hsync, 1);
    reset = 1'b1;
    rd_cnt = 0; fs_cnt = 0;
    repeat (2 * HT) step();
    check("rd_after_reset", rd_cnt, 0);
    check("frame_start_after_reset", fs_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
